// File: rtl/stereo_matrix_gain.sv
// Stereo mid/side matrix with programmable gains, one shared shift-add multiplier,
// floor scaling by 2^FRAC and saturation; one result pair per accepted sample strobe.
module stereo_matrix_gain #(
  parameter int DW   = 18,
  parameter int KW   = 4,
  parameter int FRAC = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clken_48,
  input  logic signed [DW-1:0] LEFT,
  input  logic signed [DW-1:0] RIGHT,
  input  logic        [KW-1:0] Ks,
  input  logic        [KW-1:0] Kd,
  output logic signed [DW-1:0] LI_in_LpR,
  output logic signed [DW-1:0] LI_in_LmR,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int AW = DW + KW;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [CW-1:0] LAST = CW'(KW - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(KW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(KW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL_S, MUL_D, DONE} state_t;

  state_t state, state_nxt;

  logic        [CW-1:0] cnt;
  logic signed [DW-1:0] mid_p0, side_p0;
  logic        [KW-1:0] ks_p0, kd_p0;
  logic signed [AW-1:0] acc_p1, prod_s_p1;

  logic signed [DW:0]   sum, diff;
  logic signed [DW-1:0] mul_op;
  logic                 mul_bit;
  logic                 last;
  logic signed [AW-1:0] addend, acc_nxt;

  function automatic logic signed [DW-1:0] scale_sat(input logic signed [AW-1:0] p);
    logic signed [AW-1:0] s;
    s = p >>> FRAC;
    if (s > SAT_MAX)      scale_sat = SAT_MAX[DW-1:0];
    else if (s < SAT_MIN) scale_sat = SAT_MIN[DW-1:0];
    else                  scale_sat = s[DW-1:0];
  endfunction

  // The halved sum/difference of two DW-bit values always fits DW bits.
  assign sum  = {LEFT[DW-1], LEFT} + {RIGHT[DW-1], RIGHT};
  assign diff = {LEFT[DW-1], LEFT} - {RIGHT[DW-1], RIGHT};

  assign last    = (cnt == LAST);
  assign mul_op  = (state == MUL_S) ? mid_p0 : side_p0;
  assign mul_bit = (state == MUL_S) ? ks_p0[cnt] : kd_p0[cnt];
  assign addend  = mul_bit ? (AW'(mul_op) <<< cnt) : '0;
  assign acc_nxt = acc_p1 + addend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clken_48) state_nxt = MUL_S;
      MUL_S:   if (last)     state_nxt = MUL_D;
      MUL_D:   if (last)     state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Strobes that land on any non-idle cycle, DONE included, are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             overrun <= 1'b0;
    else if (clken_48 && state != IDLE)    overrun <= 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      mid_p0    <= '0;
      side_p0   <= '0;
      ks_p0     <= '0;
      kd_p0     <= '0;
      acc_p1    <= '0;
      prod_s_p1 <= '0;
      LI_in_LpR <= '0;
      LI_in_LmR <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clken_48) begin
            mid_p0  <= DW'(sum >>> 1);
            side_p0 <= DW'(diff >>> 1);
            ks_p0   <= Ks;
            kd_p0   <= Kd;
            acc_p1  <= '0;
            cnt     <= '0;
          end
        end
        MUL_S: begin
          if (last) begin
            prod_s_p1 <= acc_nxt;
            acc_p1    <= '0;
            cnt       <= '0;
          end else begin
            acc_p1 <= acc_nxt;
            cnt    <= cnt + CW'(1);
          end
        end
        MUL_D: begin
          acc_p1 <= acc_nxt;
          cnt    <= last ? '0 : cnt + CW'(1);
        end
        DONE: begin
          LI_in_LpR <= scale_sat(prod_s_p1);
          LI_in_LmR <= scale_sat(acc_p1);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_matrix_gain.sv
// Directed bench for stereo_matrix_gain: table of mid/side vectors plus
// hand-written sequences for hold, back-to-back, overrun and reset cases.
module tb_stereo_matrix_gain;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               clken_48 = 1'b0;
  logic signed [17:0] LEFT = '0, RIGHT = '0;
  logic        [3:0]  Ks = '0, Kd = '0;
  logic signed [17:0] LI_in_LpR, LI_in_LmR;
  logic               out_valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  stereo_matrix_gain #(.DW(18), .KW(4), .FRAC(3)) dut (
    .clock(clock), .reset(reset), .clken_48(clken_48),
    .LEFT(LEFT), .RIGHT(RIGHT), .Ks(Ks), .Kd(Kd),
    .LI_in_LpR(LI_in_LpR), .LI_in_LmR(LI_in_LmR),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic signed [17:0] l, r;
    logic        [3:0]  ks, kd;
    logic signed [17:0] em, es;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic signed [17:0] l, input logic signed [17:0] r,
                        input logic [3:0] ks, input logic [3:0] kd);
    LEFT = l; RIGHT = r; Ks = ks; Kd = kd;
  endtask

  // Strobe one sample and check latency, busy length, both outputs and a single-cycle pulse.
  task automatic do_sample(input vec_t v, input string nm, input bit now);
    int lat, bcnt;
    bit got;
    if (!now) @(negedge clock);
    set_in(v.l, v.r, v.ks, v.kd);
    clken_48 = 1'b1;
    @(negedge clock);
    clken_48 = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      if (busy) bcnt++;
      if (out_valid) got = 1'b1;
    end
    chk({nm, "_latency"}, lat, 9);
    chk({nm, "_lpr"}, int'(LI_in_LpR), int'(v.em));
    chk({nm, "_lmr"}, int'(LI_in_LmR), int'(v.es));
    chk({nm, "_busy_cycles"}, bcnt, 9);
    @(negedge clock);
    chk({nm, "_valid_pulse_end"}, int'(out_valid), 0);
  endtask

  initial begin
    vec_t a, b;
    int vcnt;

    vecs[0] = '{18'sd1000,    18'sd200,     4'd8,  4'd4,  18'sd600,     18'sd200};
    vecs[1] = '{18'sd3,       18'sd0,       4'd1,  4'd1,  18'sd0,       18'sd0};
    vecs[2] = '{-18'sd3,      18'sd0,       4'd1,  4'd5,  -18'sd1,      -18'sd2};
    vecs[3] = '{18'sd131071,  18'sd131071,  4'd15, 4'd15, 18'sd131071,  18'sd0};
    vecs[4] = '{-18'sd131072, -18'sd131072, 4'd15, 4'd15, -18'sd131072, 18'sd0};
    vecs[5] = '{18'sd131071,  -18'sd131072, 4'd15, 4'd15, -18'sd2,      18'sd131071};
    vecs[6] = '{18'sd5000,    -18'sd7000,   4'd0,  4'd0,  18'sd0,       18'sd0};
    vecs[7] = '{-18'sd1000,   18'sd300,     4'd7,  4'd9,  -18'sd307,    -18'sd732};
    vecs[8] = '{18'sd1001,    18'sd0,       4'd15, 4'd15, 18'sd937,     18'sd937};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_lpr", int'(LI_in_LpR), 0);
    chk("rst_lmr", int'(LI_in_LmR), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) do_sample(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // Inputs changing while busy must not disturb the captured sample
    @(negedge clock);
    set_in(18'sd1000, 18'sd200, 4'd8, 4'd4);
    clken_48 = 1'b1;
    @(negedge clock);
    clken_48 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k <= 8) set_in(18'($urandom), 18'($urandom), 4'($urandom), 4'($urandom));
    end
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_lpr", int'(LI_in_LpR), 600);
    chk("hold_lmr", int'(LI_in_LmR), 200);

    // Strobes exactly 10 cycles apart: both accepted, no overrun
    a = vecs[0];
    b = vecs[7];
    vcnt = 0;
    @(negedge clock);
    set_in(a.l, a.r, a.ks, a.kd);
    clken_48 = 1'b1;
    @(negedge clock);
    clken_48 = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clock);
      clken_48 = 1'b0;
      if (out_valid) vcnt++;
      if (k == 9) begin
        chk("b2b_first_valid", int'(out_valid), 1);
        chk("b2b_first_lpr", int'(LI_in_LpR), int'(a.em));
        set_in(b.l, b.r, b.ks, b.kd);
        clken_48 = 1'b1;
      end
      if (k == 19) begin
        chk("b2b_second_valid", int'(out_valid), 1);
        chk("b2b_second_lpr", int'(LI_in_LpR), int'(b.em));
        chk("b2b_second_lmr", int'(LI_in_LmR), int'(b.es));
      end
    end
    chk("b2b_valid_count", vcnt, 2);
    chk("b2b_overrun", int'(overrun), 0);

    // Second strobe 4 cycles after the first is dropped and flags overrun
    vcnt = 0;
    set_in(a.l, a.r, a.ks, a.kd);
    clken_48 = 1'b1;
    @(negedge clock);
    clken_48 = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      clken_48 = 1'b0;
      if (out_valid) vcnt++;
      if (k == 3) begin
        set_in(b.l, b.r, b.ks, b.kd);
        clken_48 = 1'b1;
      end
      if (k == 9) begin
        chk("ovr_lpr", int'(LI_in_LpR), int'(a.em));
        chk("ovr_lmr", int'(LI_in_LmR), int'(a.es));
      end
    end
    chk("ovr_valid_count", vcnt, 1);
    chk("ovr_flag", int'(overrun), 1);
    do_sample(vecs[2], "after_ovr", 1'b0);
    chk("ovr_sticky", int'(overrun), 1);

    // Asynchronous reset mid-multiply discards the sample
    do_sample(vecs[0], "pre_rst", 1'b0);
    set_in(b.l, b.r, b.ks, b.kd);
    clken_48 = 1'b1;
    @(negedge clock);
    clken_48 = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_lpr", int'(LI_in_LpR), 0);
    chk("mid_rst_lmr", int'(LI_in_LmR), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    @(negedge clock);
    reset = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (out_valid) vcnt++;
    end
    chk("mid_rst_no_valid", vcnt, 0);
    do_sample(vecs[7], "post_rst", 1'b0);

    // Strobe coincident with the DONE edge counts as overrun
    vcnt = 0;
    @(negedge clock);
    set_in(a.l, a.r, a.ks, a.kd);
    clken_48 = 1'b1;
    @(negedge clock);
    clken_48 = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      clken_48 = 1'b0;
      if (out_valid) vcnt++;
      if (k == 8) clken_48 = 1'b1;
      if (k == 9) chk("done_strobe_lpr", int'(LI_in_LpR), int'(a.em));
    end
    chk("done_strobe_valid_count", vcnt, 1);
    chk("done_strobe_overrun", int'(overrun), 1);

    // Strobe on the very first edge after reset release is accepted
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    do_sample(vecs[5], "first_edge", 1'b1);
    chk("first_edge_overrun", int'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/stereo_matrix_gain.md
# stereo_matrix_gain

Parametrised stereo matrix stage for the FM stereo modulator, running in the audio sample-rate domain. On each sample strobe it forms the mid (L+R)/2 and side (L−R)/2 signals, scales each by a programmable unsigned gain using one shared shift-add multiplier, and divides by 2^FRAC. Results are saturated to the sample width and presented with a one-cycle valid strobe to the downstream interpolator. It supersedes the fixed 18-bit, dual-multiplier, edge-triggered matrix stage: one clock, a proper busy/valid handshake, saturation, and overrun detection.

## Interface
- DW, 18: sample width (signed two's complement) for inputs and outputs; ≥ 4.
- KW, 4: gain width (unsigned); also the number of multiply iterations per product; ≥ 1.
- FRAC, 3: arithmetic right shift applied to each product; 0 ≤ FRAC < DW+KW.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clken_48  in  1  sample strobe; one-cycle pulse per audio sample.
- LEFT  in  DW  signed left sample; sampled on an accepted strobe.
- RIGHT  in  DW  signed right sample; sampled on an accepted strobe.
- Ks  in  KW  unsigned mid gain; sampled on an accepted strobe.
- Kd  in  KW  unsigned side gain; sampled on an accepted strobe.
- LI_in_LpR  out  DW  signed scaled mid output (registered).
- LI_in_LmR  out  DW  signed scaled side output (registered).
- out_valid  out  1  one-cycle pulse: both outputs updated this cycle.
- busy  out  1  high while a sample is in progress (state ≠ IDLE).
- overrun  out  1  sticky: a strobe arrived while busy.

## Operation
- Matrix: mid = (LEFT+RIGHT)>>>1 and side = (LEFT−RIGHT)>>>1, computed in DW+1 bits. The results always fit DW bits exactly; truncate toward −∞ (floor).
- Capture on an accepted strobe: mid, side, Ks and Kd are registered. Input changes while busy have no effect on the sample in progress.
- Multiplier: one shared signed×unsigned shift-add unit with a DW+KW-bit signed accumulator.
  - Per iteration i = 0..KW−1: if gain bit i = 1, add operand<<i.
  - Mid (× Ks) is computed first, then side (× Kd).
  - Gain 0 gives product 0.
- Scaling: product >>> FRAC (floor), then saturate to [−2^(DW−1), 2^(DW−1)−1].
- FSM:
  - IDLE: strobe → capture, MUL_S.
  - MUL_S: KW cycles, then → MUL_D (mid product held in a register).
  - MUL_D: KW cycles, then → DONE.
  - DONE: 1 cycle. Register both saturated outputs, pulse out_valid, → IDLE.
- Strobe while state ≠ IDLE (including DONE): the strobe is dropped, overrun is set, and the in-progress sample completes normally. overrun clears only on reset.
- Both outputs hold their values between updates; they never update separately.
- Reset (asynchronous, any time, including mid-multiply):
  - FSM → IDLE; accumulator and registers cleared.
  - LI_in_LpR = 0, LI_in_LmR = 0, out_valid = 0, busy = 0, overrun = 0.
  - The in-progress sample is discarded; no out_valid follows.

## Timing
- Label the edge that samples an accepted strobe as E0.
- busy is high from after E0 until after E(2·KW+1).
- Mid iterations occur on E1..E(KW); side iterations on E(KW+1)..E(2·KW).
- Outputs and out_valid update on E(2·KW+1); out_valid is high for exactly that one cycle.
- Latency is 2·KW+1 clocks: 9 with defaults.
- Throughput: the next strobe is accepted at E(2·KW+2) or later. The minimum strobe spacing is 2·KW+2 clocks (10 with defaults), far below the sample period.
- A strobe coincident with the DONE edge counts as overrun.
- After reset deassertion, a strobe on the first clock edge is accepted.

## Test plan
- Nominal: LEFT=1000, RIGHT=200, Ks=8, Kd=4 → after 9 clocks, LpR=600 and LmR=200; out_valid high for one cycle; busy high for 9 cycles.
- Rounding/negatives: LEFT=3, RIGHT=0, Ks=1 → LpR=0. LEFT=−3, RIGHT=0, Kd=5 → side=−2, product −10, LmR=−2.
- Saturation:
  - LEFT=RIGHT=131071, Ks=15 → LpR=131071 (unsaturated value would be 245758); Kd=15 → LmR=0.
  - LEFT=RIGHT=−131072, Ks=15 → LpR=−131072.
  - LEFT=131071, RIGHT=−131072, Kd=15 → LmR=131071.
- Zero gain / input hold: Ks=0, Kd=0 → both outputs 0. Change LEFT, RIGHT, Ks and Kd on cycles 1–8 after the strobe → the result reflects the captured values only.
- Overrun: a second strobe 4 cycles after the first → first result correct, no second out_valid, overrun=1 and it stays set. A strobe exactly 10 cycles after the first → accepted, overrun unchanged.
- Reset mid-operation: assert reset 5 cycles after a strobe → outputs 0, busy 0, no out_valid. A strobe after release → correct result 9 cycles later.
